// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice.
// Holds the ALU control code constants, the largest legal control code,
// the default operand/control widths and the output FSM state type.
// The optional control-code check in alu_arbiter is enabled by defining
// ALU_ARB_CTRL_CHECK_EN; that check compares against ALU_CTRL_MAX below.
package alu_pkg;

   localparam int ALU_DATA_W_DEF = 32;
   localparam int ALU_CTRL_W_DEF = 5;

   localparam int ALU_ADD  = 0;
   localparam int ALU_SUB  = 1;
   localparam int ALU_SLL  = 2;
   localparam int ALU_SLT  = 3;
   localparam int ALU_SLTU = 4;
   localparam int ALU_XOR  = 5;
   localparam int ALU_SRL  = 6;
   localparam int ALU_SRA  = 7;
   localparam int ALU_OR   = 8;
   localparam int ALU_AND  = 9;
   localparam int ALU_MUL  = 10;
   localparam int ALU_MULH = 11;
   localparam int ALU_CEQ  = 12;
   localparam int ALU_CNE  = 13;
   localparam int ALU_CLT  = 14;
   localparam int ALU_CGE  = 15;
   localparam int ALU_CLTU = 16;
   localparam int ALU_CGEU = 17;

   localparam int ALU_CTRL_MAX = ALU_CGEU;

   // EMPTY: no response held; FULL: resp_valid is asserted.
   typedef enum logic {
      ARB_EMPTY = 1'b0,
      ARB_FULL  = 1'b1
   } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant logic with its last-grant history register.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   req0, req1        - requester valid flags
//   slot_free         - the output slot can accept a new operation this cycle
//   grant0, grant1    - one-hot (or zero) grant, combinational
module rr_arb2 (
   input  logic clk,
   input  logic rst_n,
   input  logic req0,
   input  logic req1,
   input  logic slot_free,
   output logic grant0,
   output logic grant1
);

   // 1 means req1 was granted last, so req0 wins the next contention.
   logic last_grant;

   // A lone requester always wins; under contention the one not granted
   // last time goes first.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (slot_free) begin
         if (req0 && req1) begin
            if (last_grant) grant0 = 1'b1;
            else            grant1 = 1'b1;
         end else if (req0) begin
            grant0 = 1'b1;
         end else if (req1) begin
            grant1 = 1'b1;
         end
      end
   end

   // History only moves when a transfer actually happens.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      last_grant <= 1'b1;
      else if (grant0) last_grant <= 1'b0;
      else if (grant1) last_grant <= 1'b1;
   end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared combinational ALU and registers
// the result into a single-entry response slot (1-cycle latency).
// Ports:
//   clk, rst_n                     - clock, asynchronous active-low reset
//   reqN_valid / reqN_ready        - request handshake for requester N
//   reqN_l, reqN_r, reqN_ctrl      - operands and ALU control code
//   alu_l, alu_r, alu_ctrl         - drive to the external ALU (0 when idle)
//   alu_result                     - combinational result from the ALU
//   resp_valid / resp_ready        - response handshake
//   resp_result, resp_id, resp_err - registered result, winner, error flag
// Optional feature: define ALU_ARB_CTRL_CHECK_EN to reject control codes above
// ALU_CTRL_MAX (result forced to 0, resp_err set); otherwise codes pass
// through unchanged and resp_err is tied low.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int DATA_W = ALU_DATA_W_DEF,
   parameter int CTRL_W = ALU_CTRL_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_l,
   input  logic [DATA_W-1:0] req0_r,
   input  logic [CTRL_W-1:0] req0_ctrl,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_l,
   input  logic [DATA_W-1:0] req1_r,
   input  logic [CTRL_W-1:0] req1_ctrl,
   output logic [DATA_W-1:0] alu_l,
   output logic [DATA_W-1:0] alu_r,
   output logic [CTRL_W-1:0] alu_ctrl,
   input  logic [DATA_W-1:0] alu_result,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_result,
   output logic              resp_id,
   output logic              resp_err
);

   arb_state_t        state;
   arb_state_t        state_next;
   logic              slot_free;
   logic              grant0;
   logic              grant1;
   logic              grant;
   logic [CTRL_W-1:0] sel_ctrl;
   logic              ctrl_bad;

   // rst_n gates the slot so no ready can rise while reset is held.
   assign slot_free  = rst_n && ((state == ARB_EMPTY) || resp_ready);
   assign grant      = grant0 || grant1;
   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign resp_valid = (state == ARB_FULL);

   rr_arb2 u_rr_arb2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .req0      (req0_valid),
      .req1      (req1_valid),
      .slot_free (slot_free),
      .grant0    (grant0),
      .grant1    (grant1)
   );

   // The ALU sees only the granted request; it sees zeros when idle.
   always_comb begin
      alu_l    = '0;
      alu_r    = '0;
      sel_ctrl = '0;
      if (grant0) begin
         alu_l    = req0_l;
         alu_r    = req0_r;
         sel_ctrl = req0_ctrl;
      end else if (grant1) begin
         alu_l    = req1_l;
         alu_r    = req1_r;
         sel_ctrl = req1_ctrl;
      end
   end

`ifdef ALU_ARB_CTRL_CHECK_EN
   // Illegal codes are still accepted, but the ALU is handed code 0.
   assign ctrl_bad = grant && (sel_ctrl > CTRL_W'(ALU_CTRL_MAX));
   assign alu_ctrl = ctrl_bad ? '0 : sel_ctrl;

   // Error flag travels with its result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     resp_err <= 1'b0;
      else if (grant) resp_err <= ctrl_bad;
   end
`else
   assign ctrl_bad = 1'b0;
   assign alu_ctrl = sel_ctrl;
   assign resp_err = 1'b0;
`endif

   // Output FSM: a grant always fills the slot; it empties only when the
   // consumer takes the result and nothing new replaces it.
   always_comb begin
      state_next = state;
      case (state)
         ARB_EMPTY: if (grant) state_next = ARB_FULL;
         ARB_FULL:  if (resp_ready && !grant) state_next = ARB_EMPTY;
         default:   state_next = ARB_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ARB_EMPTY;
      else        state <= state_next;
   end

   // Response payload only loads on a grant, so it holds under backpressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_result <= '0;
         resp_id     <= 1'b0;
      end else if (grant) begin
         resp_result <= ctrl_bad ? '0 : alu_result;
         resp_id     <= grant1;
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter, with a small ALU model
// attached to the alu_* ports. Adapts its expectations when
// ALU_ARB_CTRL_CHECK_EN is defined.
module tb_alu_arbiter;
   import alu_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_l, req0_r, req1_l, req1_r;
   logic [4:0]  req0_ctrl, req1_ctrl;
   logic [31:0] alu_l, alu_r, alu_result;
   logic [4:0]  alu_ctrl;
   logic        resp_valid, resp_ready, resp_id, resp_err;
   logic [31:0] resp_result;

   int error_count;
   int check_count;

   alu_arbiter #(.DATA_W(32), .CTRL_W(5)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req0_valid  (req0_valid),
      .req0_ready  (req0_ready),
      .req0_l      (req0_l),
      .req0_r      (req0_r),
      .req0_ctrl   (req0_ctrl),
      .req1_valid  (req1_valid),
      .req1_ready  (req1_ready),
      .req1_l      (req1_l),
      .req1_r      (req1_r),
      .req1_ctrl   (req1_ctrl),
      .alu_l       (alu_l),
      .alu_r       (alu_r),
      .alu_ctrl    (alu_ctrl),
      .alu_result  (alu_result),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_result (resp_result),
      .resp_id     (resp_id),
      .resp_err    (resp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in for the shared ALU: just the codes the vectors use.
   always_comb begin
      alu_result = 32'd0;
      case (alu_ctrl)
         5'(ALU_ADD): alu_result = alu_l + alu_r;
         5'(ALU_SUB): alu_result = alu_l - alu_r;
         5'(ALU_XOR): alu_result = alu_l ^ alu_r;
         default:     alu_result = 32'd0;
      endcase
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      check_count++;
      if (observed !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input int which, input logic valid,
                                input logic [31:0] l, input logic [31:0] r,
                                input logic [4:0] ctrl);
      if (which == 0) begin
         req0_valid = valid; req0_l = l; req0_r = r; req0_ctrl = ctrl;
      end else begin
         req1_valid = valid; req1_l = l; req1_r = r; req1_ctrl = ctrl;
      end
   endtask

   task automatic stepCycle;
      @(posedge clk);
      #1;
   endtask

   task automatic pulseReset;
      rst_n = 1'b0;
      stepCycle();
      stepCycle();
      rst_n = 1'b1;
      #1;
   endtask

   int          exp_ready0 [4];
   logic [31:0] exp_res [4];

   initial begin
      error_count = 0;
      check_count = 0;
      rst_n       = 1'b0;
      resp_ready  = 1'b1;
      applyStimulus(0, 1'b1, 32'd1, 32'd1, 5'd0);
      applyStimulus(1, 1'b0, 32'd0, 32'd0, 5'd0);
      stepCycle();
      stepCycle();

      // Reset state, with a request pending
      checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("rst_req0_ready", 32'(req0_ready), 32'd0);
      checkOutput("rst_resp_result", resp_result, 32'd0);
      checkOutput("rst_resp_id", 32'(resp_id), 32'd0);
      checkOutput("rst_resp_err", 32'(resp_err), 32'd0);

      // Single request: 5 + 3
      rst_n = 1'b1;
      applyStimulus(0, 1'b1, 32'd5, 32'd3, 5'(ALU_ADD));
      #1;
      checkOutput("single_req0_ready", 32'(req0_ready), 32'd1);
      checkOutput("single_req1_ready", 32'(req1_ready), 32'd0);
      checkOutput("single_alu_l", alu_l, 32'd5);
      checkOutput("single_alu_r", alu_r, 32'd3);
      stepCycle();
      applyStimulus(0, 1'b0, 32'd0, 32'd0, 5'd0);
      #1;
      checkOutput("single_resp_valid", 32'(resp_valid), 32'd1);
      checkOutput("single_resp_result", resp_result, 32'd8);
      checkOutput("single_resp_id", 32'(resp_id), 32'd0);
      checkOutput("idle_alu_l", alu_l, 32'd0);
      checkOutput("idle_alu_ctrl", 32'(alu_ctrl), 32'd0);
      stepCycle();
      checkOutput("single_drain", 32'(resp_valid), 32'd0);

      // Contention from a fresh reset: 10-4=6 for req0, 7+7=14 for req1
      pulseReset();
      exp_ready0 = '{1, 0, 1, 0};
      exp_res    = '{32'd6, 32'd14, 32'd6, 32'd14};
      applyStimulus(0, 1'b1, 32'd10, 32'd4, 5'(ALU_SUB));
      applyStimulus(1, 1'b1, 32'd7, 32'd7, 5'(ALU_ADD));
      for (int i = 0; i < 4; i++) begin
         #1;
         checkOutput($sformatf("cont_ready0_%0d", i), 32'(req0_ready), 32'(exp_ready0[i]));
         checkOutput($sformatf("cont_ready1_%0d", i), 32'(req1_ready), 32'(1 - exp_ready0[i]));
         stepCycle();
         checkOutput($sformatf("cont_id_%0d", i), 32'(resp_id), 32'(1 - exp_ready0[i]));
         checkOutput($sformatf("cont_res_%0d", i), resp_result, exp_res[i]);
      end
      applyStimulus(0, 1'b0, 32'd0, 32'd0, 5'd0);
      applyStimulus(1, 1'b0, 32'd0, 32'd0, 5'd0);
      stepCycle();

      // Backpressure: hold 100-1=99 while req1 (2+3) waits
      resp_ready = 1'b0;
      applyStimulus(0, 1'b1, 32'd100, 32'd1, 5'(ALU_SUB));
      stepCycle();
      applyStimulus(0, 1'b0, 32'd0, 32'd0, 5'd0);
      applyStimulus(1, 1'b1, 32'd2, 32'd3, 5'(ALU_ADD));
      for (int i = 0; i < 3; i++) begin
         #1;
         checkOutput($sformatf("bp_req1_ready_%0d", i), 32'(req1_ready), 32'd0);
         checkOutput($sformatf("bp_valid_%0d", i), 32'(resp_valid), 32'd1);
         checkOutput($sformatf("bp_result_%0d", i), resp_result, 32'd99);
         checkOutput($sformatf("bp_id_%0d", i), 32'(resp_id), 32'd0);
         stepCycle();
      end
      resp_ready = 1'b1;
      #1;
      checkOutput("bp_release_ready", 32'(req1_ready), 32'd1);
      stepCycle();
      applyStimulus(1, 1'b0, 32'd0, 32'd0, 5'd0);
      checkOutput("bp_release_result", resp_result, 32'd5);
      checkOutput("bp_release_id", 32'(resp_id), 32'd1);

      // Reset while FULL
      resp_ready = 1'b0;
      applyStimulus(1, 1'b1, 32'd1, 32'd1, 5'(ALU_ADD));
      stepCycle();
      checkOutput("mid_full", 32'(resp_valid), 32'd1);
      rst_n = 1'b0;
      applyStimulus(0, 1'b1, 32'd3, 32'd4, 5'(ALU_ADD));
      #1;
      checkOutput("mid_rst_valid", 32'(resp_valid), 32'd0);
      checkOutput("mid_rst_result", resp_result, 32'd0);
      checkOutput("mid_rst_ready0", 32'(req0_ready), 32'd0);
      checkOutput("mid_rst_ready1", 32'(req1_ready), 32'd0);
      stepCycle();
      rst_n = 1'b1;
      resp_ready = 1'b1;
      #1;
      checkOutput("post_rst_ready0", 32'(req0_ready), 32'd1);
      checkOutput("post_rst_ready1", 32'(req1_ready), 32'd0);
      stepCycle();
      applyStimulus(0, 1'b0, 32'd0, 32'd0, 5'd0);
      applyStimulus(1, 1'b0, 32'd0, 32'd0, 5'd0);
      checkOutput("post_rst_result", resp_result, 32'd7);
      checkOutput("post_rst_id", 32'(resp_id), 32'd0);
      stepCycle();

      // Out-of-range control code 20, then confirm it counted for round-robin
      pulseReset();
      applyStimulus(0, 1'b1, 32'd9, 32'd9, 5'd20);
      #1;
`ifdef ALU_ARB_CTRL_CHECK_EN
      checkOutput("ctrl_alu_ctrl", 32'(alu_ctrl), 32'd0);
`else
      checkOutput("ctrl_alu_ctrl", 32'(alu_ctrl), 32'd20);
`endif
      checkOutput("ctrl_ready0", 32'(req0_ready), 32'd1);
      stepCycle();
`ifdef ALU_ARB_CTRL_CHECK_EN
      checkOutput("ctrl_resp_err", 32'(resp_err), 32'd1);
      checkOutput("ctrl_resp_result", resp_result, 32'd0);
`else
      checkOutput("ctrl_resp_err", 32'(resp_err), 32'd0);
`endif
      applyStimulus(0, 1'b1, 32'd6, 32'd3, 5'(ALU_XOR));
      applyStimulus(1, 1'b1, 32'd6, 32'd3, 5'(ALU_SUB));
      #1;
      checkOutput("ctrl_rr_ready1", 32'(req1_ready), 32'd1);
      stepCycle();
      applyStimulus(0, 1'b0, 32'd0, 32'd0, 5'd0);
      checkOutput("ctrl_rr_result", resp_result, 32'd3);
      checkOutput("ctrl_rr_err", 32'(resp_err), 32'd0);

      // Streaming: req1 only, (20+3i)-i = 20+2i, no bubbles
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1, 1'b1, 32'(20 + 3 * i), 32'(i), 5'(ALU_SUB));
         #1;
         checkOutput($sformatf("stream_ready_%0d", i), 32'(req1_ready), 32'd1);
         stepCycle();
         checkOutput($sformatf("stream_valid_%0d", i), 32'(resp_valid), 32'd1);
         checkOutput($sformatf("stream_result_%0d", i), resp_result, 32'(20 + 2 * i));
         checkOutput($sformatf("stream_id_%0d", i), 32'(resp_id), 32'd1);
      end
      applyStimulus(1, 1'b0, 32'd0, 32'd0, 5'd0);
      stepCycle();
      checkOutput("stream_drain", 32'(resp_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", error_count, check_count);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32: operand and result width.
REQ-002 SHALL have parameter CTRL_W, default 5: ALU control code width.
REQ-003 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have ports req0_valid/req1_valid, input, 1: requester has an operation pending.
REQ-006 SHALL have ports req0_ready/req1_ready, output, 1: operation accepted this cycle.
REQ-007 SHALL have ports req0_l/req1_l and req0_r/req1_r, input, DATA_W: left and right operands.
REQ-008 SHALL have ports req0_ctrl/req1_ctrl, input, CTRL_W: ALU control code.
REQ-009 SHALL have ports alu_l, alu_r (output, DATA_W) and alu_ctrl (output, CTRL_W): drive the shared combinational ALU.
REQ-010 SHALL have port alu_result, input, DATA_W: combinational ALU result.
REQ-011 SHALL have ports resp_valid (output, 1), resp_ready (input, 1), resp_result (output, DATA_W), resp_id (output, 1: winning requester), and resp_err (output, 1).

Function
REQ-012 SHALL transfer a request only on the cycle where reqN_valid and reqN_ready are both high.
REQ-013 SHALL assert at most one reqN_ready per cycle.
REQ-014 SHALL grant a request only when slot_free = !resp_valid || resp_ready.
REQ-015 SHALL use a two-state output FSM: EMPTY (resp_valid=0) and FULL (resp_valid=1).
REQ-016 SHALL move EMPTY->FULL on a grant; FULL->EMPTY on resp_ready with no grant; stay FULL on resp_ready with a grant; stay FULL while resp_ready=0.
REQ-017 SHALL arbitrate round-robin: with a single valid requester, grant it; with both valid, grant the requester not granted last.
REQ-018 SHALL update last_grant only on an actual transfer.
REQ-019 SHALL, in the grant cycle, drive alu_l/alu_r/alu_ctrl combinationally from the granted requester and capture alu_result into resp_result at the next edge (1-cycle latency).
REQ-020 SHALL drive alu_l, alu_r and alu_ctrl to 0 when there is no grant.
REQ-021 SHALL hold resp_result, resp_id and resp_err stable while resp_valid=1 and resp_ready=0.
REQ-022 SHALL sustain one result per cycle when resp_ready is held at 1.
REQ-023 SHALL not let a requester change its operands after ready without a new transfer; the block does not store unaccepted requests.

Reset
REQ-024 SHALL, while rst_n=0, force state EMPTY, resp_valid=0, resp_result=0, resp_id=0, resp_err=0, and last_grant=1, so that req0 wins the first contention.
REQ-025 SHALL discard any in-flight response on reset mid-operation and deassert both reqN_ready while in reset.

Configuration
REQ-026 SHALL, with ALU_ARB_CTRL_CHECK_EN defined, accept a request whose ctrl exceeds ALU_CTRL_MAX (17) normally, but hold alu_ctrl at 0, respond with resp_result=0 and resp_err=1, and still count it as a grant for round-robin.
REQ-027 SHALL, without ALU_ARB_CTRL_CHECK_EN, forward every ctrl code unchanged and tie resp_err to 0.

Structure
REQ-028 SHALL take the ALU control code constants (ALU_ADD=0 through ALU_CGEU=17), ALU_CTRL_MAX and the CTRL_W/DATA_W defaults from shared package alu_pkg.
REQ-029 SHALL place the two-way round-robin grant logic and the last_grant register in sub-module rr_arb2; the FSM, output register and muxing stay in alu_arbiter.

Verification
REQ-030 SHALL cover single request: req0 {l=5, r=3, ctrl=0}, resp_ready=1 -> req0_ready=1 in the grant cycle; next cycle resp_valid=1, resp_result=8, resp_id=0.
REQ-031 SHALL cover contention: both valid for 4 cycles, resp_ready=1 -> grants 0,1,0,1 and resp_id sequence 0,1,0,1.
REQ-032 SHALL cover backpressure: FULL with resp_ready=0 for 3 cycles, req1 valid -> req1_ready=0 and resp fields stable; on resp_ready=1, req1 is granted in that same cycle.
REQ-033 SHALL cover reset mid-operation: rst_n low while FULL -> resp_valid=0 immediately; the first contention after release grants req0.
REQ-034 SHALL cover the macro: req0 ctrl=20 with ALU_ARB_CTRL_CHECK_EN -> resp_err=1, resp_result=0, alu_ctrl=0; without the macro -> alu_ctrl=20 and resp_err=0.
REQ-035 SHALL cover streaming: req1 only, 8 back-to-back SUB ops with resp_ready=1 -> 8 consecutive resp_valid cycles with no bubble.
